// File: rtl/usb_rx.sv
// ---------------------------------------------------------------------------
// usb_rx -- USB low/full-speed receive front end.
//
// Recovers bytes from the D+/D- line state. The line runs through a 2-flop
// synchronizer. A phase counter realigns on every line edge and samples the
// middle of each bit (4 clk per bit). Received bits are NRZI-decoded and
// unstuffed. An FSM finds SYNC, assembles bytes LSB first and detects EOP.
//
// Ports:
//   clk     in   system clock, 4x the USB bit rate
//   reset   in   synchronous, active-high reset
//   d       in   line state {D+,D-} (J, K, SE0), asynchronous to clk
//   data    out  last received byte, held until the next valid strobe
//   valid   out  1-clk strobe: data holds a new byte
//   active  out  high from SYNC accepted until EOP or abort
//   eop     out  1-clk strobe at packet end
//   err     out  1-clk strobe on a receive error
//
// Build option:
//   USB_RX_STUFF_ERR_EN  when defined, a 1 where a stuff bit is expected
//                        aborts the packet with err. Otherwise that bit is
//                        dropped like a normal stuff bit.
// ---------------------------------------------------------------------------
package types;
   // {D+, D-}: J is the full-speed idle state (D+ high).
   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_K   = 2'b01,
      LS_J   = 2'b10,
      LS_SE1 = 2'b11
   } d_port_t;
endpackage

module usb_rx (
   input  logic           clk,
   input  logic           reset,
   input  types::d_port_t d,
   output logic [7:0]     data,
   output logic           valid,
   output logic           active,
   output logic           eop,
   output logic           err
);
   import types::*;

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_DATA, S_WAIT_EOP, S_EOP_J
   } state_t;

   d_port_t    r_sync1, r_sync2, r_line, r_prev;
   logic [1:0] r_phase;
   state_t     r_state, w_state_nx;
   logic [2:0] r_ones, w_ones_nx;
   logic [2:0] r_bit_cnt, w_bit_cnt_nx;
   logic [3:0] r_aux_cnt, w_aux_cnt_nx;
   logic [7:0] r_shift, w_shift_nx;
   logic [7:0] r_data, w_data_nx;
   logic       r_valid, w_valid_nx;
   logic       r_eop, w_eop_nx;
   logic       r_err, w_err_nx;
   logic       r_active, w_active_nx;
   logic       w_sample, w_se0, w_bit;
   logic [7:0] w_shift_in;

   // r_line is the synchronized line state. The phase counter restarts on
   // the clk where r_line takes a new value. Phase 2 is then the middle of
   // that bit, and every 4th clk after it while the line holds still.
   assign w_sample   = (r_phase == 2'd2);
   // SE1 is illegal on the bus and is treated like SE0.
   assign w_se0      = (r_line == LS_SE0) || (r_line == LS_SE1);
   // NRZI: no change from the previous sample is a 1.
   assign w_bit      = (r_line == r_prev);
   assign w_shift_in = {w_bit, r_shift[7:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= LS_J;
         r_sync2 <= LS_J;
         r_line  <= LS_J;
         r_prev  <= LS_J;
         r_phase <= 2'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so the
         // three synchronizer stages shift instead of collapsing into one.
         r_sync1 <= d;
         r_sync2 <= r_sync1;
         r_line  <= r_sync2;
         r_phase <= (r_sync2 != r_line) ? 2'd0 : r_phase + 2'd1;
         // SE0 carries no NRZI information, so it leaves the history alone.
         if (w_sample && !w_se0) r_prev <= r_line;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ones    <= 3'd0;
         r_bit_cnt <= 3'd0;
         r_aux_cnt <= 4'd0;
         r_shift   <= 8'h00;
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
         r_eop     <= 1'b0;
         r_err     <= 1'b0;
         r_active  <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_ones    <= w_ones_nx;
         r_bit_cnt <= w_bit_cnt_nx;
         r_aux_cnt <= w_aux_cnt_nx;
         r_shift   <= w_shift_nx;
         r_data    <= w_data_nx;
         r_valid   <= w_valid_nx;
         r_eop     <= w_eop_nx;
         r_err     <= w_err_nx;
         r_active  <= w_active_nx;
      end
   end

   // r_aux_cnt counts bit times in SYNC and SE0 bit times in EOP_J. In
   // WAIT_EOP it flags that SE0 has been seen.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      w_state_nx   = r_state;
      w_ones_nx    = r_ones;
      w_bit_cnt_nx = r_bit_cnt;
      w_aux_cnt_nx = r_aux_cnt;
      w_shift_nx   = r_shift;
      w_data_nx    = r_data;
      w_valid_nx   = 1'b0;
      w_eop_nx     = 1'b0;
      w_err_nx     = 1'b0;
      w_active_nx  = r_active;
      if (w_sample) begin
         case (r_state)
            S_IDLE: begin
               if (r_line == LS_K) begin
                  w_state_nx   = S_SYNC;
                  // Seed with ones so a SYNC match needs five real zeros.
                  w_shift_nx   = {w_bit, 7'h7F};
                  w_aux_cnt_nx = 4'd1;
               end
            end
            S_SYNC: begin
               if (w_se0) begin
                  w_state_nx = S_IDLE;
               end else if (w_shift_in[7:2] == 6'b100000) begin
                  w_state_nx   = S_DATA;
                  w_active_nx  = 1'b1;
                  w_bit_cnt_nx = 3'd0;
                  // The closing 1 of SYNC starts the run of ones.
                  w_ones_nx    = 3'd1;
               end else if (r_aux_cnt == 4'd11) begin
                  w_state_nx = S_IDLE;
               end else begin
                  w_shift_nx   = w_shift_in;
                  w_aux_cnt_nx = r_aux_cnt + 4'd1;
               end
            end
            S_DATA: begin
               if (w_se0) begin
                  w_state_nx   = S_EOP_J;
                  w_aux_cnt_nx = 4'd1;
               end else if (r_ones == 3'd6) begin
                  // This bit is a stuff bit and never reaches the shifter.
                  w_ones_nx = 3'd0;
`ifdef USB_RX_STUFF_ERR_EN
                  if (w_bit) begin
                     w_err_nx     = 1'b1;
                     w_active_nx  = 1'b0;
                     w_state_nx   = S_WAIT_EOP;
                     w_aux_cnt_nx = 4'd0;
                  end
`endif
               end else begin
                  w_ones_nx    = w_bit ? r_ones + 3'd1 : 3'd0;
                  w_shift_nx   = w_shift_in;
                  w_bit_cnt_nx = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     w_data_nx  = w_shift_in;
                     w_valid_nx = 1'b1;
                  end
               end
            end
            S_EOP_J: begin
               if (r_line == LS_J) begin
                  w_eop_nx    = 1'b1;
                  // A partial byte at EOP is discarded and reported.
                  w_err_nx    = (r_bit_cnt != 3'd0);
                  w_active_nx = 1'b0;
                  w_state_nx  = S_IDLE;
               end else if (r_line == LS_K || r_aux_cnt == 4'd3) begin
                  w_err_nx    = 1'b1;
                  w_active_nx = 1'b0;
                  w_state_nx  = S_IDLE;
               end else begin
                  w_aux_cnt_nx = r_aux_cnt + 4'd1;
               end
            end
            S_WAIT_EOP: begin
               if (w_se0) begin
                  w_aux_cnt_nx = 4'd1;
               end else if (r_line == LS_J && r_aux_cnt != 4'd0) begin
                  w_state_nx = S_IDLE;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   assign data   = r_data;
   assign valid  = r_valid;
   assign active = r_active;
   assign eop    = r_eop;
   assign err    = r_err;

endmodule

// File: tb/tb_usb_rx.sv
// ---------------------------------------------------------------------------
// tb_usb_rx -- directed self-checking bench for usb_rx.
//
// Packets are built as lists of line symbols, one per bit time. The builder
// adds SYNC, bit stuffing, NRZI coding and EOP. Each symbol is held for
// 4 clk, or jittered by up to +-1 clk at line transitions. A negedge
// monitor collects received bytes and counts the strobes.
// ---------------------------------------------------------------------------
module tb_usb_rx;
   import types::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   d_port_t    d = LS_J;
   logic [7:0] data;
   logic       valid, active, eop, err;

   usb_rx dut (
      .clk    (clk),
      .reset  (reset),
      .d      (d),
      .data   (data),
      .valid  (valid),
      .active (active),
      .eop    (eop),
      .err    (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   // ---------------- monitor ----------------
   logic [7:0] rx_q[$];
   int   n_eop, n_err, n_eop_err, n_rise, n_bad, t_valid, t_eop;
   logic err_act, act_q = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (valid) begin
            rx_q.push_back(data);
            t_valid = cyc;
            if (!active) n_bad++;
         end
         if (eop) begin
            n_eop++;
            t_eop = cyc;
         end
         if (err) begin
            n_err++;
            err_act = active;
         end
         if (eop && err) n_eop_err++;
         if (active && !act_q) n_rise++;
      end
      act_q = active;
   end

   task automatic clear_mon();
      rx_q.delete();
      n_eop = 0; n_err = 0; n_eop_err = 0; n_rise = 0; n_bad = 0;
      t_valid = -1; t_eop = -1; err_act = 1'b0;
   endtask

   // ---------------- packet builder ----------------
   d_port_t sym_q[$];
   d_port_t lvl;
   int      ones;
   logic    stuff_val = 1'b0;

   task automatic put_raw(input logic b);
      if (!b) lvl = (lvl == LS_J) ? LS_K : LS_J;
      sym_q.push_back(lvl);
   endtask

   task automatic put_bit(input logic b);
      put_raw(b);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
         put_raw(stuff_val);
         stuff_val = 1'b0;
         ones = 0;
      end
   endtask

   task automatic put_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) put_bit(b[i]);
   endtask

   task automatic begin_pkt();
      sym_q.delete();
      lvl  = LS_J;
      ones = 0;
      repeat (3) sym_q.push_back(LS_J);
      put_byte(8'h80);
   endtask

   task automatic end_pkt();
      sym_q.push_back(LS_SE0);
      sym_q.push_back(LS_SE0);
      repeat (4) sym_q.push_back(LS_J);
   endtask

   // Called and returns at posedge+1.
   task automatic send(input bit jit);
      int cur, nxt, dur;
      cur = 0;
      for (int k = 0; k < sym_q.size(); k++) begin
         dur = 4;
         if (jit && (k + 1 < sym_q.size()) && (sym_q[k+1] != sym_q[k])) begin
            nxt = cur + int'($urandom_range(2)) - 1;
            if (nxt > 1)  nxt = 1;
            if (nxt < -1) nxt = -1;
            dur = dur + nxt - cur;
            cur = nxt;
         end
         d = sym_q[k];
         repeat (dur) @(posedge clk);
         #1;
      end
   endtask

   task automatic settle();
      repeat (12) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
      n_checks++; if (eop !== 1'b0) begin n_fail++; $display("FAIL reset_eop: got %b expected 0", eop); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      clear_mon();
      begin_pkt(); put_byte(8'hA5); put_byte(8'h3C); end_pkt();
      send(1'b0); settle();
      n_checks++; if (rx_q.size() !== 2) begin n_fail++; $display("FAIL basic_count: got %0d expected 2", rx_q.size()); end
      if (rx_q.size() >= 2) begin
         n_checks++; if (rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL basic_byte0: got %h expected a5", rx_q[0]); end
         n_checks++; if (rx_q[1] !== 8'h3C) begin n_fail++; $display("FAIL basic_byte1: got %h expected 3c", rx_q[1]); end
      end
      n_checks++; if (n_eop !== 1) begin n_fail++; $display("FAIL basic_eop: got %0d expected 1", n_eop); end
      n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL basic_err: got %0d expected 0", n_err); end
      n_checks++; if (n_rise !== 1) begin n_fail++; $display("FAIL basic_active_rise: got %0d expected 1", n_rise); end
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL basic_active_end: got %b expected 0", active); end
      n_checks++; if (n_bad !== 0) begin n_fail++; $display("FAIL basic_valid_inactive: got %0d expected 0", n_bad); end
      n_checks++; if (!(t_valid >= 0 && t_valid < t_eop)) begin n_fail++; $display("FAIL basic_order: valid at %0d eop at %0d, valid must come first", t_valid, t_eop); end
   endtask

   task automatic test_stuffing();
      clear_mon();
      begin_pkt(); put_byte(8'hFF); put_byte(8'h01); end_pkt();
      send(1'b0); settle();
      n_checks++; if (rx_q.size() !== 2) begin n_fail++; $display("FAIL stuff_count: got %0d expected 2", rx_q.size()); end
      if (rx_q.size() >= 2) begin
         n_checks++; if (rx_q[0] !== 8'hFF) begin n_fail++; $display("FAIL stuff_byte0: got %h expected ff", rx_q[0]); end
         n_checks++; if (rx_q[1] !== 8'h01) begin n_fail++; $display("FAIL stuff_byte1: got %h expected 01", rx_q[1]); end
      end
      n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL stuff_err: got %0d expected 0", n_err); end
      n_checks++; if (n_eop !== 1) begin n_fail++; $display("FAIL stuff_eop: got %0d expected 1", n_eop); end
   endtask

   task automatic test_stuff_violation();
      clear_mon();
      begin_pkt();
      stuff_val = 1'b1;
      put_byte(8'hFF); put_byte(8'h81); put_byte(8'h42); end_pkt();
      send(1'b0); settle();
`ifdef USB_RX_STUFF_ERR_EN
      n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL stuffv_valid: got %0d bytes expected 0", rx_q.size()); end
      n_checks++; if (n_err !== 1) begin n_fail++; $display("FAIL stuffv_err: got %0d expected 1", n_err); end
      n_checks++; if (n_eop !== 0) begin n_fail++; $display("FAIL stuffv_eop: got %0d expected 0", n_eop); end
      n_checks++; if (err_act !== 1'b0) begin n_fail++; $display("FAIL stuffv_active_at_err: got %b expected 0", err_act); end
`else
      n_checks++; if (rx_q.size() !== 3) begin n_fail++; $display("FAIL stuffv_count: got %0d expected 3", rx_q.size()); end
      if (rx_q.size() >= 3) begin
         n_checks++; if (rx_q[0] !== 8'hFF) begin n_fail++; $display("FAIL stuffv_byte0: got %h expected ff", rx_q[0]); end
         n_checks++; if (rx_q[1] !== 8'h81) begin n_fail++; $display("FAIL stuffv_byte1: got %h expected 81", rx_q[1]); end
         n_checks++; if (rx_q[2] !== 8'h42) begin n_fail++; $display("FAIL stuffv_byte2: got %h expected 42", rx_q[2]); end
      end
      n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL stuffv_err: got %0d expected 0", n_err); end
      n_checks++; if (n_eop !== 1) begin n_fail++; $display("FAIL stuffv_eop: got %0d expected 1", n_eop); end
`endif
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL stuffv_active_end: got %b expected 0", active); end
   endtask

   task automatic test_partial_byte();
      clear_mon();
      begin_pkt();
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
      end_pkt();
      send(1'b0); settle();
      n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL partial_valid: got %0d bytes expected 0", rx_q.size()); end
      n_checks++; if (n_eop !== 1) begin n_fail++; $display("FAIL partial_eop: got %0d expected 1", n_eop); end
      n_checks++; if (n_err !== 1) begin n_fail++; $display("FAIL partial_err: got %0d expected 1", n_err); end
      n_checks++; if (n_eop_err !== 1) begin n_fail++; $display("FAIL partial_same_clk: got %0d expected 1", n_eop_err); end
   endtask

   task automatic test_reset_mid_packet();
      clear_mon();
      begin_pkt(); put_byte(8'hC3);
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
      send(1'b0);
      n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL rstmid_active_before: got %b expected 1", active); end
      n_checks++; if (!(rx_q.size() == 1 && rx_q[0] == 8'hC3)) begin n_fail++; $display("FAIL rstmid_first_byte: got %0d bytes expected one c3", rx_q.size()); end
      reset = 1'b1;
      d = LS_J;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h expected 00", data); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL rstmid_active: got %b expected 0", active); end
      n_checks++; if (eop !== 1'b0) begin n_fail++; $display("FAIL rstmid_eop: got %b expected 0", eop); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b expected 0", err); end
      @(posedge clk);
      #1 reset = 1'b0;
      clear_mon();
      repeat (20) @(posedge clk);
      #1;
      n_checks++; if (rx_q.size() + n_eop + n_err !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d strobes expected 0", rx_q.size() + n_eop + n_err); end
      clear_mon();
      begin_pkt(); put_byte(8'h5A); end_pkt();
      send(1'b0); settle();
      n_checks++; if (!(rx_q.size() == 1 && rx_q[0] == 8'h5A)) begin n_fail++; $display("FAIL rstmid_restart: got %0d bytes expected one 5a", rx_q.size()); end
      n_checks++; if (n_eop !== 1) begin n_fail++; $display("FAIL rstmid_eop_after: got %0d expected 1", n_eop); end
      n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL rstmid_err_after: got %0d expected 0", n_err); end
   endtask

   task automatic test_jitter();
      logic [7:0] exp_b[$];
      int n;
      clear_mon();
      begin_pkt();
      for (int i = 0; i < 16; i++) begin
         exp_b.push_back(8'($urandom));
         put_byte(exp_b[i]);
      end
      end_pkt();
      send(1'b1); settle();
      n_checks++; if (rx_q.size() !== 16) begin n_fail++; $display("FAIL jitter_count: got %0d expected 16", rx_q.size()); end
      n = (rx_q.size() < 16) ? rx_q.size() : 16;
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (rx_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL jitter_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]); end
      end
      n_checks++; if (n_eop !== 1) begin n_fail++; $display("FAIL jitter_eop: got %0d expected 1", n_eop); end
      n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL jitter_err: got %0d expected 0", n_err); end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_basic();
      test_stuffing();
      test_stuff_violation();
      test_partial_byte();
      test_reset_mid_packet();
      test_jitter();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/usb_rx.md
USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 Parameters: none; timing is fixed at 4 clk per USB bit time (low speed 6 MHz, full speed 48 MHz).
REQ-002 clk  input  1  system clock, 4x bit rate.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 d  input  types::d_port_t  USB port D+,D- line state (J, K, SE0), asynchronous to clk.
REQ-005 data  output  8  received byte, LSB first on the wire; held stable until the next valid pulse.
REQ-006 valid  output  1  single-cycle strobe: data holds a new byte.
REQ-007 active  output  1  high from SYNC accepted until EOP detected or abort.
REQ-008 eop  output  1  single-cycle strobe at packet end.
REQ-009 err  output  1  single-cycle strobe on receive error.

Function
REQ-010 d SHALL pass through a 2-flop synchronizer; all later timing references the synchronized value.
REQ-011 Phase counter (2 bit) SHALL clear on every synchronized line-state change; the line is sampled when the counter equals 2 (mid-bit), and then once per 4 clk while the state is stable.
REQ-012 NRZI decode: sampled state equal to previous sample -> 1, change -> 0; previous-sample register resets to J.
REQ-013 FSM states: IDLE, SYNC, DATA, WAIT_EOP, EOP_J.
REQ-014 IDLE -> SYNC on first sampled K.
REQ-015 SYNC: accept when last six decoded bits are 0,0,0,0,0,1 (up to 2 leading SYNC bits may be lost); accept -> DATA, active=1, bit count 0; 12 bit times without accept, or SE0 sampled -> IDLE, no strobes.
REQ-016 DATA: decoded bits shift in LSB first; on the 8th non-stuff bit data is loaded and valid pulses on the following clk; bit count wraps 7->0.
REQ-017 Bit unstuffing: ones counter (3 bit) counts consecutive decoded 1s; after six 1s the next bit is dropped and the counter cleared; a decoded 0 clears the counter; SYNC's final 1 counts as the first one.
REQ-018 SE0 sampled in DATA -> EOP_J; then J sampled -> eop pulse, active=0, IDLE; K or second SE0 beyond 3 bit times in EOP_J -> err pulse, IDLE.
REQ-019 EOP with bit count != 0 (partial byte) SHALL pulse err on the same clk as eop; the partial byte is discarded (no valid).
REQ-020 valid, eop and err never assert while active=0, except eop/err at the terminating clk.
REQ-021 Simultaneous 8th bit and SE0 sample cannot occur (distinct sample points); a byte completing on the sample before SE0 SHALL produce valid before eop.

Reset
REQ-022 On reset: FSM=IDLE, data=8'h00, valid=0, active=0, eop=0, err=0, counters=0, synchronizer and NRZI history=J.
REQ-023 Reset asserted mid-packet SHALL take effect next clk with no valid/eop/err pulse; reception restarts only with a new SYNC.

Configuration
REQ-024 Macro USB_RX_STUFF_ERR_EN defined: a decoded 1 where a stuff bit is expected SHALL pulse err, drop active, enter WAIT_EOP (ignore bits, no valid) until SE0 then J, then IDLE without eop pulse.
REQ-025 Macro not defined: that bit SHALL be dropped silently as a stuff bit, ones counter cleared, reception continues; err only from REQ-018/REQ-019.

Verification
REQ-026 Idle J, SYNC, bytes 8'hA5, 8'h3C, SE0x2 bits, J -> valid twice with data A5 then 3C, then one eop, err never.
REQ-027 Byte 8'hFF then 8'h01 (stuff bit after six 1s inserted by the model) -> data FF, 01; no err.
REQ-028 Byte 8'hFF with stuff bit replaced by 1: with USB_RX_STUFF_ERR_EN -> err pulse, active=0, no valid, no eop; without -> valid FF, following bytes received.
REQ-029 SYNC, 5 data bits, SE0, J -> eop and err on same clk, no valid.
REQ-030 Reset asserted after 3 data bits of a byte -> outputs at reset values next clk; next full packet with 8'h5A received correctly.
REQ-031 Line transitions jittered +-1 clk around nominal edges for a 16-byte random packet -> all 16 bytes match, one eop.
